// File: rtl/bht_sched_pkg.sv
// Shared types and default sizing for the branch history table port scheduler.
// Contents:
//   DEF_*     default parameter values used by bht_port_sched
//   state_e   scheduler state
//   resolve_t queued resolve entry at the default index width
package bht_sched_pkg;

  localparam int unsigned DEF_IWIDTH   = 6;
  localparam int unsigned DEF_HWIDTH   = 4;
  localparam int unsigned DEF_QDEPTH   = 4;
  localparam int unsigned DEF_MAX_WAIT = 8;

  typedef enum logic [1:0] {
    IDLE,
    UPD_RD,
    UPD_WR,
    FLUSH
  } state_e;

  typedef struct packed {
    logic [DEF_IWIDTH-1:0] index;
    logic                  taken;
  } resolve_t;

endpackage

// File: rtl/bht_resolve_fifo.sv
// Synchronous FIFO holding resolved branches until the table port is free.
// Ports:
//   clk, reset        clock, asynchronous active-high reset (empties the queue)
//   push, push_data   write one entry (caller guarantees !full)
//   pop               drop the head entry (caller guarantees !empty)
//   head              current head entry
//   full, empty       registered occupancy flags
//   count             number of entries held
module bht_resolve_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 7
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/bht_port_sched.sv
// Single-port branch history table scheduler. Fetch lookups get the port by
// default; queued resolves are applied as read-then-write shifts when the port
// is idle, the queue is full, or the head has been passed over MAX_WAIT times.
// A flush request zeroes every entry, one write per cycle.
// Ports:
//   clk, reset                          clock, asynchronous active-high reset
//   lookup_valid/index/ready/hist       fetch history read (zero-cycle latency)
//   resolve_valid/index/taken/ready     execute resolve, enqueued on valid&&ready
//   flush_req, flush_busy               table clear request / in-progress flag
//   tbl_index/we/wdata/rdata            table port (rdata is a combinational read)
module bht_port_sched
  import bht_sched_pkg::*;
#(
  parameter int unsigned IWIDTH   = DEF_IWIDTH,
  parameter int unsigned HWIDTH   = DEF_HWIDTH,
  parameter int unsigned QDEPTH   = DEF_QDEPTH,
  parameter int unsigned MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              lookup_valid,
  input  logic [IWIDTH-1:0] lookup_index,
  output logic              lookup_ready,
  output logic [HWIDTH-1:0] lookup_hist,
  input  logic              resolve_valid,
  input  logic [IWIDTH-1:0] resolve_index,
  input  logic              resolve_taken,
  output logic              resolve_ready,
  input  logic              flush_req,
  output logic              flush_busy,
  output logic [IWIDTH-1:0] tbl_index,
  output logic              tbl_we,
  output logic [HWIDTH-1:0] tbl_wdata,
  input  logic [HWIDTH-1:0] tbl_rdata
);

  localparam int unsigned WW = $clog2(MAX_WAIT + 1);
  localparam int unsigned CW = $clog2(QDEPTH + 1);

  state_e            state_q;
  logic [IWIDTH-1:0] upd_index_q;
  logic              upd_taken_q;
  logic [HWIDTH-2:0] hreg_q;      // only the bits that survive the shift
  logic [WW-1:0]     wait_q;
  logic [IWIDTH-1:0] fptr_q;
  logic              fpend_q;

  logic              q_push;
  logic              q_pop;
  logic [IWIDTH:0]   q_head;
  logic              q_full;
  logic              q_empty;
  logic [CW-1:0]     q_count;
  logic              upd_start;

  bht_resolve_fifo #(
    .DEPTH (QDEPTH),
    .WIDTH (IWIDTH + 1)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (q_push),
    .push_data ({resolve_index, resolve_taken}),
    .pop       (q_pop),
    .head      (q_head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

  // A flush request in IDLE takes priority so the RMW cannot delay the clear.
  assign upd_start = (state_q == IDLE) && !q_empty && !flush_req &&
                     (!lookup_valid || q_full || (wait_q == WW'(MAX_WAIT)));

  assign q_push        = resolve_valid && !q_full;
  assign q_pop         = upd_start;
  assign resolve_ready = !q_full;
  assign flush_busy    = fpend_q || (state_q == FLUSH);

  // Port mux; held at reset values while reset is asserted.
  always_comb begin
    lookup_ready = 1'b0;
    lookup_hist  = '0;
    tbl_index    = '0;
    tbl_we       = 1'b0;
    tbl_wdata    = '0;
    if (!reset) begin
      case (state_q)
        IDLE: begin
          if (upd_start) begin
            tbl_index = q_head[IWIDTH:1];
          end else begin
            lookup_ready = 1'b1;
            tbl_index    = lookup_index;
            lookup_hist  = tbl_rdata;
          end
        end
        UPD_RD: tbl_index = upd_index_q;
        UPD_WR: begin
          tbl_we    = 1'b1;
          tbl_index = upd_index_q;
          tbl_wdata = {hreg_q, upd_taken_q};
        end
        FLUSH: begin
          tbl_we    = 1'b1;
          tbl_index = fptr_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      upd_index_q <= '0;
      upd_taken_q <= 1'b0;
      hreg_q      <= '0;
      wait_q      <= '0;
      fptr_q      <= '0;
      fpend_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (flush_req) begin
            state_q <= FLUSH;
          end else if (upd_start) begin
            state_q     <= UPD_RD;
            upd_index_q <= q_head[IWIDTH:1];
            upd_taken_q <= q_head[0];
          end
          if (upd_start || (q_count == '0)) begin
            wait_q <= '0;
          end else if (lookup_valid && (wait_q != WW'(MAX_WAIT))) begin
            wait_q <= wait_q + 1'b1;
          end
        end
        UPD_RD: begin
          hreg_q  <= tbl_rdata[HWIDTH-2:0];
          state_q <= UPD_WR;
          if (flush_req) fpend_q <= 1'b1;
        end
        UPD_WR: begin
          if (fpend_q || flush_req) begin
            fpend_q <= 1'b1;
            state_q <= FLUSH;
          end else begin
            state_q <= IDLE;
          end
        end
        FLUSH: begin
          if (fptr_q == {IWIDTH{1'b1}}) begin
            fptr_q  <= '0;
            fpend_q <= 1'b0;
            state_q <= IDLE;
          end else begin
            fptr_q <= fptr_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bht_port_sched.sv
module tb_bht_port_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic       lookup_valid;
  logic [5:0] lookup_index;
  logic       lookup_ready;
  logic [3:0] lookup_hist;
  logic       resolve_valid;
  logic [5:0] resolve_index;
  logic       resolve_taken;
  logic       resolve_ready;
  logic       flush_req;
  logic       flush_busy;
  logic [5:0] tbl_index;
  logic       tbl_we;
  logic [3:0] tbl_wdata;
  logic [3:0] tbl_rdata;

  logic [3:0] tbl [64];
  logic       preload;

  int vectors = 0;
  int miscompares = 0;
  int served;
  logic [3:0] taken_pat;

  always #5 clk = ~clk;

  bht_port_sched #(
    .IWIDTH   (6),
    .HWIDTH   (4),
    .QDEPTH   (4),
    .MAX_WAIT (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .lookup_valid  (lookup_valid),
    .lookup_index  (lookup_index),
    .lookup_ready  (lookup_ready),
    .lookup_hist   (lookup_hist),
    .resolve_valid (resolve_valid),
    .resolve_index (resolve_index),
    .resolve_taken (resolve_taken),
    .resolve_ready (resolve_ready),
    .flush_req     (flush_req),
    .flush_busy    (flush_busy),
    .tbl_index     (tbl_index),
    .tbl_we        (tbl_we),
    .tbl_wdata     (tbl_wdata),
    .tbl_rdata     (tbl_rdata)
  );

  // Table model: combinational read, clocked write.
  assign tbl_rdata = tbl[tbl_index];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) tbl[i] <= 4'h0;
      tbl[3]  <= 4'b0101;
      tbl[5]  <= 4'b0011;
      tbl[10] <= 4'b1010;
      tbl[20] <= 4'b0001;
      tbl[21] <= 4'b1111;
      tbl[22] <= 4'b1000;
      tbl[23] <= 4'b0110;
      tbl[24] <= 4'b0101;
      tbl[30] <= 4'b1001;
      tbl[40] <= 4'b0010;
    end else if (tbl_we) begin
      tbl[tbl_index] <= tbl_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at the start of an IDLE cycle in which an update must begin.
  task automatic rmw(input string tag, input logic [5:0] idx, input logic [3:0] wdata);
    #1;
    chk({tag, "_start_idx"}, tbl_index, idx);
    chk({tag, "_start_rdy"}, lookup_ready, 0);
    chk({tag, "_start_we"}, tbl_we, 0);
    tick();
    #1;
    chk({tag, "_rd"}, {tbl_we, lookup_ready, tbl_index}, {1'b0, 1'b0, idx});
    tick();
    #1;
    chk({tag, "_wr"}, {tbl_we, lookup_ready, tbl_index, tbl_wdata}, {1'b1, 1'b0, idx, wdata});
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    preload = 1'b1;
    lookup_valid = 1'b1;
    lookup_index = 6'd9;
    resolve_valid = 1'b0;
    resolve_index = '0;
    resolve_taken = 1'b0;
    flush_req = 1'b0;
    #2;
    chk("reset_outputs",
        {lookup_ready, resolve_ready, flush_busy, tbl_we, tbl_index, tbl_wdata},
        {1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 4'd0});
    @(posedge clk);
    #1;
    preload = 1'b0;
    reset = 1'b0;

    // Lookup straight after reset: zero-latency read.
    lookup_index = 6'd5;
    #1;
    chk("lookup5", {lookup_ready, tbl_index, lookup_hist}, {1'b1, 6'd5, 4'b0011});
    tick();

    // Single resolve with no lookups: write lands three cycles after the push.
    lookup_valid = 1'b0;
    resolve_valid = 1'b1;
    resolve_index = 6'd5;
    resolve_taken = 1'b1;
    #1;
    chk("push_rdy", resolve_ready, 1);
    chk("push_cycle_we", tbl_we, 0);
    tick();
    resolve_valid = 1'b0;
    rmw("single", 6'd5, 4'b0111);
    lookup_valid = 1'b1;
    lookup_index = 6'd5;
    #1;
    chk("hist5_after", {lookup_ready, lookup_hist}, {1'b1, 4'b0111});
    tick();

    // Continuous lookups with one queued resolve: 8 served, then forced.
    lookup_index = 6'd3;
    resolve_valid = 1'b1;
    resolve_index = 6'd10;
    resolve_taken = 1'b0;
    #1;
    chk("fw_push_served", {lookup_ready, lookup_hist}, {1'b1, 4'b0101});
    tick();
    resolve_valid = 1'b0;
    served = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (!lookup_ready) break;
      served++;
      tick();
    end
    chk("fw_served", served, 8);
    rmw("forced", 6'd10, 4'b0100);
    #1;
    chk("fw_resume", lookup_ready, 1);
    tick();

    // Fill the queue while lookups keep the port busy.
    lookup_index = 6'd0;
    taken_pat = 4'b1101;
    for (int i = 0; i < 4; i++) begin
      resolve_valid = 1'b1;
      resolve_index = 6'(20 + i);
      resolve_taken = taken_pat[i];
      #1;
      chk("fill_rdy", resolve_ready, 1);
      chk("fill_served", lookup_ready, 1);
      tick();
    end
    resolve_valid = 1'b0;
    #1;
    chk("full_rdy", resolve_ready, 0);
    chk("full_force", {lookup_ready, tbl_index}, {1'b0, 6'd20});
    tick();
    #1;
    chk("rdy_after_pop", resolve_ready, 1);
    chk("full_rd", {tbl_we, tbl_index}, {1'b0, 6'd20});
    tick();
    #1;
    chk("full_wr", {tbl_we, tbl_index, tbl_wdata}, {1'b1, 6'd20, 4'b0011});
    tick();
    // Count 3: push and pop together.
    lookup_valid = 1'b0;
    resolve_valid = 1'b1;
    resolve_index = 6'd24;
    resolve_taken = 1'b0;
    #1;
    chk("pp_rdy", resolve_ready, 1);
    chk("pp_start", {lookup_ready, tbl_index}, {1'b0, 6'd21});
    tick();
    resolve_valid = 1'b0;
    #1;
    chk("pp_count3", resolve_ready, 1);
    chk("pp_rd", {tbl_we, tbl_index}, {1'b0, 6'd21});
    tick();
    #1;
    chk("pp_wr", {tbl_we, tbl_index, tbl_wdata}, {1'b1, 6'd21, 4'b1110});
    tick();
    rmw("q22", 6'd22, 4'b0001);
    rmw("q23", 6'd23, 4'b1101);
    rmw("q24", 6'd24, 4'b1010);
    #1;
    chk("drained", {lookup_ready, tbl_we}, {1'b1, 1'b0});
    tick();

    // Flush requested during UPD_RD: RMW first, then 64 zero writes.
    resolve_valid = 1'b1;
    resolve_index = 6'd30;
    resolve_taken = 1'b1;
    tick();
    resolve_valid = 1'b0;
    #1;
    chk("fl_start", {lookup_ready, tbl_index}, {1'b0, 6'd30});
    tick();
    flush_req = 1'b1;
    #1;
    chk("fl_rd", {flush_busy, tbl_we, tbl_index}, {1'b0, 1'b0, 6'd30});
    tick();
    flush_req = 1'b0;
    #1;
    chk("fl_wr", {flush_busy, tbl_we, tbl_index, tbl_wdata}, {1'b1, 1'b1, 6'd30, 4'b0011});
    tick();
    for (int i = 0; i < 64; i++) begin
      resolve_valid = (i == 0);
      resolve_index = 6'd40;
      resolve_taken = 1'b1;
      lookup_valid = (i == 0);
      flush_req = (i == 10);
      #1;
      if (i == 0) chk("fl_push_rdy", resolve_ready, 1);
      chk("fl_seq", {tbl_we, tbl_wdata, tbl_index, flush_busy, lookup_ready},
          {1'b1, 4'h0, 6'(i), 1'b1, 1'b0});
      tick();
    end
    resolve_valid = 1'b0;
    lookup_valid = 1'b0;
    flush_req = 1'b0;
    #1;
    chk("fl_done_busy", flush_busy, 0);
    rmw("after_flush", 6'd40, 4'b0001);
    lookup_valid = 1'b1;
    lookup_index = 6'd5;
    #1;
    chk("fl_cleared", {lookup_ready, lookup_hist}, {1'b1, 4'h0});
    tick();

    // Reset in the middle of a flush.
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    lookup_valid = 1'b0;
    resolve_valid = 1'b1;
    resolve_index = 6'd50;
    resolve_taken = 1'b1;
    #1;
    chk("rf_ptr0", {flush_busy, tbl_we, tbl_index}, {1'b1, 1'b1, 6'd0});
    tick();
    resolve_valid = 1'b0;
    for (int i = 1; i < 20; i++) tick();
    lookup_valid = 1'b1;
    lookup_index = 6'd9;
    #1;
    chk("rf_ptr20", {tbl_we, tbl_index}, {1'b1, 6'd20});
    #1;
    reset = 1'b1;
    #1;
    chk("rf_reset_outputs",
        {lookup_ready, resolve_ready, flush_busy, tbl_we, tbl_index, tbl_wdata},
        {1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 4'd0});
    #2;
    reset = 1'b0;
    tick();
    lookup_index = 6'd7;
    #1;
    chk("rf_lookup", {lookup_ready, tbl_index}, {1'b1, 6'd7});
    tick();
    lookup_valid = 1'b0;
    #1;
    chk("rf_qempty1", {lookup_ready, tbl_we}, {1'b1, 1'b0});
    tick();
    #1;
    chk("rf_qempty2", {lookup_ready, tbl_we, flush_busy}, {1'b1, 1'b0, 1'b0});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
